// File: rtl/pc_msg_parser_if.sv
// -----------------------------------------------------------------------------
// pc_msg_parser_if
//   Signal bundle between the xb_wr_fifo read port / command consumer and
//   pc_msg_parser.
//   slave  : the parser side (pops FIFO words, presents decoded commands)
//   master : the surrounding logic (FIFO FWFT word, consumer ready)
//   FIFO side    : pc_msg_valid, pc_msg, pc_msg_ack
//   Command side : cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_seq,
//                  cmd_stride, cmd_exposure_clks, cmd_exposure
//   Status       : msg_error, err_count, busy
// -----------------------------------------------------------------------------
interface pc_msg_parser_if #(
   parameter int unsigned XB_SIZE = 32
);
   logic               pc_msg_valid;
   logic [XB_SIZE-1:0] pc_msg;
   logic               pc_msg_ack;

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_start;
   logic               cmd_stop;
   logic [7:0]         cmd_seq;
   logic [15:0]        cmd_stride;
   logic [15:0]        cmd_exposure_clks;
   logic [31:0]        cmd_exposure;

   logic               msg_error;
   logic [7:0]         err_count;
   logic               busy;

   modport slave (
      input  pc_msg_valid, pc_msg, cmd_ready,
      output pc_msg_ack, cmd_valid, cmd_start, cmd_stop, cmd_seq,
             cmd_stride, cmd_exposure_clks, cmd_exposure,
             msg_error, err_count, busy
   );

   modport master (
      output pc_msg_valid, pc_msg, cmd_ready,
      input  pc_msg_ack, cmd_valid, cmd_start, cmd_stop, cmd_seq,
             cmd_stride, cmd_exposure_clks, cmd_exposure,
             msg_error, err_count, busy
   );
endinterface

// File: rtl/pc_msg_parser.sv
// -----------------------------------------------------------------------------
// pc_msg_parser
//   Pops 32-bit PC message words from the xb_wr_fifo FWFT read port, assembles
//   3-word commands (w0 opcode/seq, w1 exposure_clks/stride, w2 float
//   exposure), validates START (opcode 0x40) / STOP (all words zero) and holds
//   one decoded command on a valid/ready interface. Malformed messages and
//   partial messages stalled longer than TIMEOUT_CLKS are discarded, pulsing
//   msg_error and bumping the saturating err_count.
//   Ports:
//     CLK     : application clock
//     RESET_N : asynchronous active-low reset
//     bus     : pc_msg_parser_if.slave (FIFO pop side, command side, status)
//   DELAY is kept for drop-in compatibility; registered outputs update at
//   the clock edge without an added delay.
// -----------------------------------------------------------------------------
module pc_msg_parser #(
   parameter int unsigned XB_SIZE      = 32,
   parameter int unsigned TIMEOUT_CLKS = 1024,
   parameter int unsigned DELAY        = 1
) (
   input logic            CLK,
   input logic            RESET_N,
   pc_msg_parser_if.slave bus
);

   localparam int unsigned IdleW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0] OpStart = 8'h40;

   if ((XB_SIZE != 32) || (TIMEOUT_CLKS < 2) || (DELAY > 1000)) begin : g_param_check
      $error("pc_msg_parser: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      W0,
      W1,
      W2,
      HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [XB_SIZE-1:0] w0_q, w0_d;
   logic [XB_SIZE-1:0] w1_q, w1_d;
   logic [IdleW-1:0]   idle_q, idle_d;

   logic               cmd_start_q, cmd_start_d;
   logic               cmd_stop_q, cmd_stop_d;
   logic [7:0]         cmd_seq_q, cmd_seq_d;
   logic [15:0]        cmd_stride_q, cmd_stride_d;
   logic [15:0]        cmd_exposure_clks_q, cmd_exposure_clks_d;
   logic [31:0]        cmd_exposure_q, cmd_exposure_d;
   logic               msg_error_q, msg_error_d;
   logic [7:0]         err_count_q, err_count_d;

   logic               ack;
   logic               is_start;
   logic               is_stop;
   logic               discard;

   // Words are only popped while assembling; HOLD (including the cycle the
   // consumer accepts) never pops.
   assign ack = bus.pc_msg_valid && (state_q != HOLD);

   // Validation uses latched w0/w1 and the live w2 on its ack cycle.
   assign is_start = (w0_q[7:0] == OpStart) && (w0_q[31:16] == '0);
   assign is_stop  = (w0_q == '0) && (w1_q == '0) && (bus.pc_msg == '0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q             <= W0;
         w0_q                <= '0;
         w1_q                <= '0;
         idle_q              <= '0;
         cmd_start_q         <= 1'b0;
         cmd_stop_q          <= 1'b0;
         cmd_seq_q           <= '0;
         cmd_stride_q        <= '0;
         cmd_exposure_clks_q <= '0;
         cmd_exposure_q      <= '0;
         msg_error_q         <= 1'b0;
         err_count_q         <= '0;
      end else begin
         state_q             <= state_d;
         w0_q                <= w0_d;
         w1_q                <= w1_d;
         idle_q              <= idle_d;
         cmd_start_q         <= cmd_start_d;
         cmd_stop_q          <= cmd_stop_d;
         cmd_seq_q           <= cmd_seq_d;
         cmd_stride_q        <= cmd_stride_d;
         cmd_exposure_clks_q <= cmd_exposure_clks_d;
         cmd_exposure_q      <= cmd_exposure_d;
         msg_error_q         <= msg_error_d;
         err_count_q         <= err_count_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      w0_d                = w0_q;
      w1_d                = w1_q;
      idle_d              = idle_q;
      cmd_start_d         = cmd_start_q;
      cmd_stop_d          = cmd_stop_q;
      cmd_seq_d           = cmd_seq_q;
      cmd_stride_d        = cmd_stride_q;
      cmd_exposure_clks_d = cmd_exposure_clks_q;
      cmd_exposure_d      = cmd_exposure_q;
      discard             = 1'b0;

      unique case (state_q)
         W0: begin
            idle_d = '0;
            if (ack) begin
               w0_d    = bus.pc_msg;
               state_d = W1;
            end
         end
         W1, W2: begin
            if (ack) begin
               idle_d = '0;
               if (state_q == W1) begin
                  w1_d    = bus.pc_msg;
                  state_d = W2;
               end else if (is_start || is_stop) begin
                  cmd_start_d         = is_start;
                  cmd_stop_d          = !is_start;
                  cmd_seq_d           = w0_q[15:8];
                  cmd_stride_d        = w1_q[15:0];
                  cmd_exposure_clks_d = w1_q[31:16];
                  cmd_exposure_d      = bus.pc_msg;
                  state_d             = HOLD;
               end else begin
                  discard = 1'b1;
                  state_d = W0;
               end
            end else if (idle_q == IdleLast) begin
               // Stalled partial message: drop it; the next word is a new w0.
               idle_d  = '0;
               discard = 1'b1;
               state_d = W0;
            end else begin
               idle_d = idle_q + IdleW'(1);
            end
         end
         HOLD: begin
            idle_d = '0;
            if (bus.cmd_ready) begin
               state_d = W0;
            end
         end
         default: begin
            state_d = W0;
         end
      endcase

      msg_error_d = discard;
      err_count_d = err_count_q;
      if (discard && (err_count_q != '1)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   assign bus.pc_msg_ack        = ack;
   assign bus.cmd_valid         = (state_q == HOLD);
   assign bus.busy              = (state_q != W0);
   assign bus.cmd_start         = cmd_start_q;
   assign bus.cmd_stop          = cmd_stop_q;
   assign bus.cmd_seq           = cmd_seq_q;
   assign bus.cmd_stride        = cmd_stride_q;
   assign bus.cmd_exposure_clks = cmd_exposure_clks_q;
   assign bus.cmd_exposure      = cmd_exposure_q;
   assign bus.msg_error         = msg_error_q;
   assign bus.err_count         = err_count_q;

endmodule
